// File: rtl/bram_decode_write_if.sv
`default_nettype none
// ============================================================================
// Module : bram_decode_write_if
// Brief  : Issue/result/bank-write bundle for the NTT write-back decoder.
// Rev    : 1.0  initial release
// ============================================================================
interface bram_decode_write_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5,
    parameter int NUM_BU     = 8
);
    logic                         issue_valid_i;
    logic                         issue_last_i;
    logic [8*NUM_BU-1:0]          addr_core_i;
    logic [7:0]                   olen_i;
    logic [DATA_WIDTH*NUM_BU-1:0] bu_a_i;
    logic [DATA_WIDTH*NUM_BU-1:0] bu_b_i;

    logic [NUM_BU-1:0]            we_a_o;
    logic [ADW*NUM_BU-1:0]        addr_a_o;
    logic [DATA_WIDTH*NUM_BU-1:0] din_a_o;
    logic [NUM_BU-1:0]            we_b_o;
    logic [ADW*NUM_BU-1:0]        addr_b_o;
    logic [DATA_WIDTH*NUM_BU-1:0] din_b_o;
    logic                         busy_o;
    logic                         done_write_o;
    logic                         conflict_o;

    modport master (
        output issue_valid_i, issue_last_i, addr_core_i, olen_i, bu_a_i, bu_b_i,
        input  we_a_o, addr_a_o, din_a_o, we_b_o, addr_b_o, din_b_o,
        input  busy_o, done_write_o, conflict_o
    );

    modport slave (
        input  issue_valid_i, issue_last_i, addr_core_i, olen_i, bu_a_i, bu_b_i,
        output we_a_o, addr_a_o, din_a_o, we_b_o, addr_b_o, din_b_o,
        output busy_o, done_write_o, conflict_o
    );
endinterface
`default_nettype wire

// File: rtl/bram_decode_write.sv
`default_nettype none
// ============================================================================
// Module : bram_decode_write
// Brief  : NTT write-back decoder: delays issued address groups by the
//          butterfly latency and crossbars results onto 8 dual-port banks.
//          Optional bank-conflict detection under BANK_CONFLICT_CHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module bram_decode_write #(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5,
    parameter int NUM_BU     = 8,
    parameter int BU_LAT     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bram_decode_write_if.slave bus
);

    localparam int TAIL = BU_LAT - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BU_LAT-1:0]   dl_valid_q, dl_valid_d;
    logic [BU_LAT-1:0]   dl_last_q,  dl_last_d;
    logic [8*NUM_BU-1:0] dl_addr_q [BU_LAT];
    logic [8*NUM_BU-1:0] dl_addr_d [BU_LAT];
    logic [7:0]          dl_olen_q [BU_LAT];
    logic [7:0]          dl_olen_d [BU_LAT];

    logic                issue_accept;
    logic                tail_valid;
    logic                tail_last;
    logic [7:0]          lane_a_addr [NUM_BU];
    logic [7:0]          lane_b_addr [NUM_BU];
    logic                hit_a;
    logic                hit_b;

    logic [NUM_BU-1:0]            we_a_d,   we_a_q;
    logic [ADW*NUM_BU-1:0]        addr_a_d, addr_a_q;
    logic [DATA_WIDTH*NUM_BU-1:0] din_a_d,  din_a_q;
    logic [NUM_BU-1:0]            we_b_d,   we_b_q;
    logic [ADW*NUM_BU-1:0]        addr_b_d, addr_b_q;
    logic [DATA_WIDTH*NUM_BU-1:0] din_b_d,  din_b_q;
    logic                         last_out_d, last_out_q;
    logic                         done_d,     done_q;
    logic                         busy_d,     busy_q;

    // Issues arriving while the stage drains belong to no stage and are dropped.
    assign issue_accept = bus.issue_valid_i && (state_q != ST_DRAIN);

    always_comb begin
        dl_valid_d = '0;
        dl_last_d  = '0;
        for (int j = 0; j < BU_LAT; j++) begin
            dl_addr_d[j] = '0;
            dl_olen_d[j] = '0;
        end
        dl_valid_d[0] = issue_accept;
        dl_last_d[0]  = issue_accept && bus.issue_last_i;
        dl_addr_d[0]  = bus.addr_core_i;
        dl_olen_d[0]  = bus.olen_i;
        for (int j = 1; j < BU_LAT; j++) begin
            dl_valid_d[j] = dl_valid_q[j-1];
            dl_last_d[j]  = dl_last_q[j-1];
            dl_addr_d[j]  = dl_addr_q[j-1];
            dl_olen_d[j]  = dl_olen_q[j-1];
        end
    end

    assign tail_valid = dl_valid_q[TAIL];
    assign tail_last  = dl_last_q[TAIL];

    always_comb begin
        for (int i = 0; i < NUM_BU; i++) begin
            lane_a_addr[i] = dl_addr_q[TAIL][8*i +: 8];
            lane_b_addr[i] = lane_a_addr[i] + dl_olen_q[TAIL];
        end
    end

    // Per-bank priority select: the first lane (lowest index) targeting a bank owns it.
    always_comb begin
        we_a_d   = '0;
        addr_a_d = '0;
        din_a_d  = '0;
        we_b_d   = '0;
        addr_b_d = '0;
        din_b_d  = '0;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        if (tail_valid) begin
            for (int k = 0; k < NUM_BU; k++) begin
                hit_a = 1'b0;
                hit_b = 1'b0;
                for (int i = 0; i < NUM_BU; i++) begin
                    if (!hit_a && (lane_a_addr[i][7:5] == 3'(k))) begin
                        hit_a                            = 1'b1;
                        addr_a_d[ADW*k +: ADW]           = lane_a_addr[i][ADW-1:0];
                        din_a_d[DATA_WIDTH*k +: DATA_WIDTH] = bus.bu_a_i[DATA_WIDTH*i +: DATA_WIDTH];
                    end
                    if (!hit_b && (lane_b_addr[i][7:5] == 3'(k))) begin
                        hit_b                            = 1'b1;
                        addr_b_d[ADW*k +: ADW]           = lane_b_addr[i][ADW-1:0];
                        din_b_d[DATA_WIDTH*k +: DATA_WIDTH] = bus.bu_b_i[DATA_WIDTH*i +: DATA_WIDTH];
                    end
                end
                we_a_d[k] = hit_a;
                we_b_d[k] = hit_b;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.issue_valid_i) begin
                    state_d = bus.issue_last_i ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.issue_valid_i && bus.issue_last_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // last_out_q marks the cycle the final write sits on the bank ports.
                if (last_out_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d     = (state_q != ST_IDLE);
    assign last_out_d = tail_valid && tail_last;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            dl_valid_q <= '0;
            dl_last_q  <= '0;
            for (int j = 0; j < BU_LAT; j++) begin
                dl_addr_q[j] <= '0;
                dl_olen_q[j] <= '0;
            end
            we_a_q     <= '0;
            addr_a_q   <= '0;
            din_a_q    <= '0;
            we_b_q     <= '0;
            addr_b_q   <= '0;
            din_b_q    <= '0;
            last_out_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_valid_q <= dl_valid_d;
            dl_last_q  <= dl_last_d;
            for (int j = 0; j < BU_LAT; j++) begin
                dl_addr_q[j] <= dl_addr_d[j];
                dl_olen_q[j] <= dl_olen_d[j];
            end
            we_a_q     <= we_a_d;
            addr_a_q   <= addr_a_d;
            din_a_q    <= din_a_d;
            we_b_q     <= we_b_d;
            addr_b_q   <= addr_b_d;
            din_b_q    <= din_b_d;
            last_out_q <= last_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef BANK_CONFLICT_CHK_EN
    logic clash_d, clash_q;
    logic conflict_d, conflict_q;

    always_comb begin
        clash_d = 1'b0;
        if (tail_valid) begin
            for (int i = 0; i < NUM_BU; i++) begin
                for (int j = i + 1; j < NUM_BU; j++) begin
                    if ((lane_a_addr[i][7:5] == lane_a_addr[j][7:5]) ||
                        (lane_b_addr[i][7:5] == lane_b_addr[j][7:5])) begin
                        clash_d = 1'b1;
                    end
                end
            end
        end
        conflict_d = conflict_q || clash_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            clash_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            clash_q    <= clash_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.conflict_o = conflict_q;
`else
    assign bus.conflict_o = 1'b0;
`endif

    assign bus.we_a_o       = we_a_q;
    assign bus.addr_a_o     = addr_a_q;
    assign bus.din_a_o      = din_a_q;
    assign bus.we_b_o       = we_b_q;
    assign bus.addr_b_o     = addr_b_q;
    assign bus.din_b_o      = din_b_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_write_o = done_q;

endmodule
`default_nettype wire
